instr_fetch: RTL and testbench
==============================

Name: instr_fetch

Overview:
Fetch stage of the 16-bit CPU. It sits directly upstream of the 16K x 16 instruction memory. It owns the PC and drives the memory's 14-bit address and read enable. It captures the returned instruction into the IF/ID pipeline register. Stalls come from the hazard unit and redirects from branch resolution; a HALT opcode stops fetch.

Parameters:
RESET_PC, 14'h0000, PC value loaded on reset.
NOP_INSTR, 16'h0000, bubble word written into IF/ID on flush/halt; must decode as a no-op.
HALT_OP, 4'hF, opcode field instr[15:12] identifying HALT.

Ports:
clk  in  1  system clock; all state updates on posedge.
rst  in  1  synchronous, active-high reset.
stall  in  1  hold PC and IF/ID this cycle; stable before the falling edge.
br_taken  in  1  redirect fetch to br_target and flush IF/ID.
br_target  in  14  redirect address.
addr_IM  out  14  instruction memory address, equal to the PC register.
rd_en_IM  out  1  instruction memory read enable.
instr_IM  in  16  instruction memory data, valid after the falling edge of the cycle in which rd_en_IM=1.
instr_IF_ID  out  16  registered instruction to decode.
pc_IF_ID  out  14  registered address+1 of instr_IF_ID.
valid_IF_ID  out  1  instr_IF_ID is a real instruction (0 = bubble).
halted  out  1  fetch is stopped on HALT.

Behaviour:
- Memory timing: the memory samples addr_IM on the negedge when rd_en_IM=1 and holds its output otherwise. The PC changes only on posedge, so the address is stable half a cycle before the memory samples it. The instruction for PC p is latched into IF/ID at the posedge ending the cycle that presented p.
- State machine, 2 states: FETCH and HALT.
- rd_en_IM = (state==FETCH) & ~stall, combinational.
- addr_IM = pc, combinational from the register.
- Reset (rst=1 at posedge), highest priority, also mid-operation:
  - pc=RESET_PC, state=FETCH.
  - instr_IF_ID=NOP_INSTR, pc_IF_ID=0, valid_IF_ID=0, halted=0.
  - During reset rd_en_IM follows the rule above (1 if stall=0); this is harmless.
- Priority at each posedge with rst=0: br_taken > stall > normal.
- br_taken=1 (any state, also while stall=1):
  - pc<=br_target, state<=FETCH, halted<=0.
  - IF/ID<=NOP_INSTR with valid 0; pc_IF_ID holds its value.
- stall=1, br_taken=0: pc, state and all IF/ID outputs hold. The memory output holds because rd_en_IM=0.
- FETCH, normal (no stall, no br_taken):
  - IF/ID<=instr_IM, pc_IF_ID<=pc+1, valid<=1.
  - If instr_IM[15:12]==HALT_OP: state<=HALT, halted<=1, pc holds (addr_IM stays at the HALT address).
  - Otherwise pc<=pc+1.
- HALT, no br_taken:
  - IF/ID<=NOP_INSTR with valid 0.
  - pc holds; rd_en_IM=0.
  - Only br_taken (a speculative HALT behind a branch) or rst leaves HALT.
- Arithmetic: pc+1 is 14-bit modulo, so 14'h3FFF -> 14'h0000. The same wrap applies to pc_IF_ID.
- HALT detection checks only an instruction actually accepted into IF/ID. It never checks one seen during stall or on a br_taken cycle.
- One instruction per cycle at full throughput; latency from address presentation to IF/ID is 1 cycle.

Test Plan:
- Reset then run, mem[0..3]=1111,2222,3333,4444 -> on successive posedges IF/ID = 1111/pc 1, 2222/pc 2, 3333/pc 3, all valid=1. While rst=1: valid=0, addr_IM=0.
- stall=1 for 2 cycles when addr_IM=2 -> rd_en_IM=0, addr_IM=2, IF/ID holds 2222 valid=1. Release -> next IF/ID 3333, pc_IF_ID=3.
- br_taken=1 with stall=1, br_target=0x0100, mem[0x100]=0xA5A5 -> next cycle valid=0, instr=NOP, addr_IM=0x0100. Following cycle IF/ID=A5A5, pc_IF_ID=0x0101.
- mem[5]=0xF123 -> IF/ID=F123 valid=1 and halted=1 together. Thereafter rd_en_IM=0, addr_IM=5, valid=0 every cycle.
- While halted, br_taken with target 0x0010 -> halted=0, rd_en_IM=1, addr_IM=0x0010, fetch resumes normally.
- br_target=0x3FFF, mem[0x3FFF]=0x1234 -> IF/ID pc_IF_ID=0x0000, next addr_IM=0x0000. Then rst asserted mid-run -> all outputs return to reset values on the next posedge.

Source files
------------

// File: rtl/instr_fetch_if.sv
// Fetch-stage bus: hazard/branch controls in, instruction memory port,
// and the IF/ID pipeline register outputs toward decode.
interface instr_fetch_if;
    logic        stall;
    logic        br_taken;
    logic [13:0] br_target;
    logic [13:0] addr_IM;
    logic        rd_en_IM;
    logic [15:0] instr_IM;
    logic [15:0] instr_IF_ID;
    logic [13:0] pc_IF_ID;
    logic        valid_IF_ID;
    logic        halted;

    // The fetch stage itself
    modport master (
        input  stall,
        input  br_taken,
        input  br_target,
        input  instr_IM,
        output addr_IM,
        output rd_en_IM,
        output instr_IF_ID,
        output pc_IF_ID,
        output valid_IF_ID,
        output halted
    );

    // Everything around the fetch stage (memory, hazard unit, decode)
    modport slave (
        output stall,
        output br_taken,
        output br_target,
        output instr_IM,
        input  addr_IM,
        input  rd_en_IM,
        input  instr_IF_ID,
        input  pc_IF_ID,
        input  valid_IF_ID,
        input  halted
    );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch stage of the 16-bit CPU. Owns the PC, addresses the
// 16K x 16 instruction memory (which samples on negedge) and registers the
// returned word into IF/ID. Stalls hold everything, branches redirect and
// flush, and a HALT opcode parks fetch until a branch or reset.
module instr_fetch #(
    parameter logic [13:0] RESET_PC  = 14'h0000,
    parameter logic [15:0] NOP_INSTR = 16'h0000,
    parameter logic [3:0]  HALT_OP   = 4'hF
) (
    input  logic          clk,
    input  logic          rst,
    instr_fetch_if.master bus
);

    typedef enum logic {
        S_FETCH = 1'b0,
        S_HALT  = 1'b1
    } state_t;

    state_t      state;
    logic [13:0] pc;
    logic [13:0] pc_inc;
    logic [15:0] instr_q;
    logic [13:0] pc_id_q;
    logic        valid_q;
    logic        halted_q;

    // 14-bit increment wraps naturally from 3FFF to 0000
    assign pc_inc = pc + 14'd1;

    // The memory only samples the address when fetching and not stalled,
    // so its output holds through stalls and HALT
    assign bus.rd_en_IM    = (state == S_FETCH) && !bus.stall;
    assign bus.addr_IM     = pc;
    assign bus.instr_IF_ID = instr_q;
    assign bus.pc_IF_ID    = pc_id_q;
    assign bus.valid_IF_ID = valid_q;
    assign bus.halted      = halted_q;

    // PC, FSM and IF/ID register; priority is reset > branch > stall > normal
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_FETCH;
            pc       <= RESET_PC;
            instr_q  <= NOP_INSTR;
            pc_id_q  <= 14'h0000;
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
        end else if (bus.br_taken) begin
            state    <= S_FETCH;
            pc       <= bus.br_target;
            instr_q  <= NOP_INSTR;
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
        end else if (!bus.stall) begin
            case (state)
                S_FETCH: begin
                    instr_q <= bus.instr_IM;
                    pc_id_q <= pc_inc;
                    valid_q <= 1'b1;
                    if (bus.instr_IM[15:12] == HALT_OP) begin
                        state    <= S_HALT;
                        halted_q <= 1'b1;
                    end else begin
                        pc <= pc_inc;
                    end
                end
                S_HALT: begin
                    instr_q <= NOP_INSTR;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Testbench for instr_fetch: a negedge-sampling memory model, directed
// scenarios followed by random stall/branch/reset traffic, and a
// transaction-level reference model feeding a scoreboard queue.
module tb_instr_fetch;

    typedef struct packed {
        logic [15:0] instr;
        logic [13:0] pcid;
        logic        valid;
        logic        halted;
        logic [13:0] addr;
        logic        rd_en;
    } expect_t;

    logic clk;
    logic rst;
    logic [15:0] mem [0:16383];
    logic [15:0] mem_out;

    instr_fetch_if bus ();

    instr_fetch dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    expect_t exp_q [$];
    int checks;
    int errors;
    bit driver_done;

    // Reference model state: what the stage should look like after each edge
    logic [13:0] m_pc;
    logic        m_halt;
    logic [15:0] m_instr;
    logic [13:0] m_pcid;
    logic        m_valid;

    // Inputs that were applied during the cycle just ended
    logic        p_rst;
    logic        p_stall;
    logic        p_br;
    logic [13:0] p_tgt;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory: latch the addressed word on negedge when enabled
    always @(negedge clk) begin
        if (bus.rd_en_IM)
            mem_out <= mem[bus.addr_IM];
    end
    assign bus.instr_IM = mem_out;

    task automatic check_output(input string name, input logic [15:0] actual,
                                input logic [15:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, actual, expected);
        end
    endtask

    // Advance the model by one clock edge using last cycle's inputs
    task automatic model_step();
        logic [15:0] word;
        if (p_rst) begin
            m_pc = 14'h0000; m_halt = 1'b0;
            m_instr = 16'h0000; m_pcid = 14'h0000; m_valid = 1'b0;
        end else if (p_br) begin
            m_pc = p_tgt; m_halt = 1'b0;
            m_instr = 16'h0000; m_valid = 1'b0;
        end else if (p_stall) begin
            // nothing changes
        end else if (!m_halt) begin
            word    = mem[m_pc];
            m_instr = word;
            m_pcid  = 14'(m_pc + 14'd1);
            m_valid = 1'b1;
            if (word[15:12] == 4'hF)
                m_halt = 1'b1;
            else
                m_pc = 14'(m_pc + 14'd1);
        end else begin
            m_instr = 16'h0000;
            m_valid = 1'b0;
        end
    endtask

    // Drive one cycle of inputs and queue what the monitor should see in it
    task automatic apply_stimulus(input logic r, input logic s, input logic b,
                                  input logic [13:0] t);
        expect_t e;
        @(posedge clk);
        #1;
        model_step();
        rst = r; bus.stall = s; bus.br_taken = b; bus.br_target = t;
        p_rst = r; p_stall = s; p_br = b; p_tgt = t;
        e.instr  = m_instr;
        e.pcid   = m_pcid;
        e.valid  = m_valid;
        e.halted = m_halt;
        e.addr   = m_pc;
        e.rd_en  = !m_halt && !s;
        exp_q.push_back(e);
    endtask

    // Monitor: compare DUT outputs mid-cycle against the queued expectation
    always @(negedge clk) begin
        expect_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_output("instr_IF_ID", bus.instr_IF_ID, e.instr);
            check_output("pc_IF_ID", {2'b00, bus.pc_IF_ID}, {2'b00, e.pcid});
            check_output("valid_IF_ID", {15'd0, bus.valid_IF_ID}, {15'd0, e.valid});
            check_output("halted", {15'd0, bus.halted}, {15'd0, e.halted});
            check_output("addr_IM", {2'b00, bus.addr_IM}, {2'b00, e.addr});
            check_output("rd_en_IM", {15'd0, bus.rd_en_IM}, {15'd0, e.rd_en});
        end
    end

    // Watchdog so the run always ends
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        logic [15:0] w;
        logic        r, s, b;
        logic [13:0] t;
        checks = 0;
        errors = 0;
        driver_done = 1'b0;

        for (int i = 0; i < 16384; i++) begin
            w = 16'($urandom);
            if ((i < 14'h0020 || (i >= 14'h0100 && i < 14'h0110) || i >= 14'h3FF0)
                && w[15:12] == 4'hF)
                w[15:12] = 4'h0;
            mem[i] = w;
        end
        mem[0] = 16'h1111; mem[1] = 16'h2222; mem[2] = 16'h3333; mem[3] = 16'h4444;
        mem[4] = 16'h0444; mem[5] = 16'hF123;
        mem[14'h0100] = 16'hA5A5;
        mem[14'h3FFF] = 16'h1234;

        rst = 1'b1; bus.stall = 1'b0; bus.br_taken = 1'b0; bus.br_target = 14'h0;
        p_rst = 1'b1; p_stall = 1'b0; p_br = 1'b0; p_tgt = 14'h0;
        m_pc = 14'h0; m_halt = 1'b0; m_instr = 16'h0; m_pcid = 14'h0; m_valid = 1'b0;

        // Reset, then fetch 1111 and 2222
        apply_stimulus(1, 0, 0, 14'h0000);
        apply_stimulus(0, 0, 0, 14'h0000);
        apply_stimulus(0, 0, 0, 14'h0000);
        // Stall twice with addr_IM at 2, then release
        apply_stimulus(0, 1, 0, 14'h0000);
        apply_stimulus(0, 1, 0, 14'h0000);
        apply_stimulus(0, 0, 0, 14'h0000);
        // Branch while stalled, then fetch A5A5
        apply_stimulus(0, 1, 1, 14'h0100);
        apply_stimulus(0, 0, 0, 14'h0000);
        apply_stimulus(0, 0, 0, 14'h0000);
        // Redirect to 3 and run into the HALT at 5
        apply_stimulus(0, 0, 1, 14'h0003);
        for (int i = 0; i < 7; i++) apply_stimulus(0, 0, 0, 14'h0000);
        // Branch out of HALT and resume
        apply_stimulus(0, 0, 1, 14'h0010);
        for (int i = 0; i < 3; i++) apply_stimulus(0, 0, 0, 14'h0000);
        // PC wrap at the top of memory
        apply_stimulus(0, 0, 1, 14'h3FFF);
        for (int i = 0; i < 3; i++) apply_stimulus(0, 0, 0, 14'h0000);
        // Reset in the middle of a run
        apply_stimulus(1, 0, 0, 14'h0000);
        apply_stimulus(0, 0, 0, 14'h0000);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            r = ($urandom_range(0, 63) == 0);
            s = ($urandom_range(0, 3) == 0);
            b = ($urandom_range(0, 7) == 0);
            t = ($urandom_range(0, 3) == 0) ? 14'(14'h3FFC + $urandom_range(0, 3))
                                            : 14'($urandom);
            apply_stimulus(r, s, b, t);
        end
        apply_stimulus(0, 0, 0, 14'h0000);
        driver_done = 1'b1;

        for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(posedge clk);
        if (exp_q.size() > 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end
        @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
